cbc_chain_controller: RTL and testbench
=======================================

CBC_CHAIN_CONTROLLER -- requirements
Module: cbc_chain_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles to wait for des_done after issue (1..65535).
REQ-002 Port: HCLK  in  1  sole clock; all state on rising edge.
REQ-003 Port: HRESET  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  one-cycle request: data_in holds a new block.
REQ-005 Port: mode  in  1  1=encrypt, 0=decrypt; sampled with start.
REQ-006 Port: data_in  in  64  plaintext (encrypt) or ciphertext (decrypt) block.
REQ-007 Port: iv_load  in  1  one-cycle request to load iv_in into chain register.
REQ-008 Port: iv_in  in  64  initialisation vector.
REQ-009 Port: des_enable  out  1  one-cycle start pulse to triple-DES core.
REQ-010 Port: des_encr_decr  out  1  mode forwarded to core; held stable while busy.
REQ-011 Port: des_data  out  64  block presented to core; held stable while busy.
REQ-012 Port: des_result  in  64  core output block.
REQ-013 Port: des_done  in  1  core completion pulse; des_result valid same cycle.
REQ-014 Port: result_valid  out  1  one-cycle pulse: result_data updated.
REQ-015 Port: result_data  out  64  CBC result; holds until next result.
REQ-016 Port: busy  out  1  high in any state other than IDLE.
REQ-017 Port: overrun  out  1  sticky: request arrived while busy.
REQ-018 Port: timeout  out  1  sticky: core failed to respond within TIMEOUT_CYCLES.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, OUTPUT; reset state IDLE.
REQ-020 IDLE, iv_load=1: chain <= iv_in; overrun and timeout cleared.
REQ-021 IDLE, start=1: capture mode; encrypt: des_data <= data_in XOR chain; decrypt: des_data <= data_in, saved_ct <= data_in; go ISSUE.
REQ-022 IDLE, iv_load and start same cycle: IV load first; block uses the new iv_in as chain.
REQ-023 ISSUE: des_enable=1 for exactly this cycle; timeout counter cleared to 0; go WAIT next cycle.
REQ-024 WAIT: counter increments each cycle des_done=0; saturates, no wrap.
REQ-025 WAIT, des_done=1, encrypt: result_data <= des_result; chain <= des_result; go OUTPUT.
REQ-026 WAIT, des_done=1, decrypt: result_data <= des_result XOR chain; chain <= saved_ct; go OUTPUT.
REQ-027 WAIT, counter reaches TIMEOUT_CYCLES with des_done=0: timeout <= 1; chain, result_data unchanged; no result_valid; go IDLE.
REQ-028 des_done on the exact timeout cycle: des_done wins, normal completion, timeout not set.
REQ-029 OUTPUT: result_valid=1 for this cycle only; go IDLE next cycle.
REQ-030 Latency: start at cycle N -> des_enable at N+1; des_done at cycle M -> result_valid at M+1; next start accepted at M+2.
REQ-031 start or iv_load while busy=1: request ignored (no state change), overrun <= 1.
REQ-032 des_done outside WAIT: ignored, no flag.
REQ-033 All XOR is bitwise 64-bit; no arithmetic carry.

Reset
REQ-034 HRESET low: state IDLE; chain, saved_ct, des_data, result_data, counter = 0; des_enable, des_encr_decr, result_valid, busy, overrun, timeout = 0.
REQ-035 Reset asserted mid-operation aborts the block immediately; no result_valid after release; later des_done ignored until next issue.

Verification
REQ-036 Encrypt chain: iv=0, start data_in=64'h0123456789ABCDEF, core model returns ~des_data after 3 cycles -> des_data=64'h0123456789ABCDEF, result_data=64'hFEDCBA9876543210; second block data_in=0 -> des_data=64'hFEDCBA9876543210.
REQ-037 Decrypt chain: iv=64'h1111111111111111, data_in=64'hAAAAAAAAAAAAAAAA, core returns 64'h5555555555555555 -> result_data=64'h4444444444444444, chain=64'hAAAAAAAAAAAAAAAA.
REQ-038 Overrun: start asserted in WAIT -> overrun=1, des_data unchanged, single result_valid; iv_load in IDLE clears overrun.
REQ-039 Timeout: TIMEOUT_CYCLES=8, core never responds -> timeout=1 exactly 8 cycles after des_enable, busy=0, result_valid never pulses.
REQ-040 Reset mid-WAIT: HRESET low during WAIT -> all outputs 0 at once; des_done after release produces no result_valid.
REQ-041 Simultaneous iv_load+start in IDLE, mode=encrypt, iv_in=64'hFF, data_in=64'h0F -> des_data=64'hF0.

Source files
------------

// File: rtl/cbc_chain_controller.sv
// CBC chaining wrapper around an external triple-DES core: XORs blocks with the
// chain register, issues them to the core and forms the chained result.
module cbc_chain_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] data_in,
  input  logic        iv_load,
  input  logic [63:0] iv_in,
  output logic        des_enable,
  output logic        des_encr_decr,
  output logic [63:0] des_data,
  input  logic [63:0] des_result,
  input  logic        des_done,
  output logic        result_valid,
  output logic [63:0] result_data,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [63:0] chain_q;
  logic [63:0] saved_ct_q;
  logic [63:0] des_data_q;
  logic [63:0] result_data_q;
  logic [15:0] cnt_q;
  logic        des_enable_q;
  logic        mode_q;
  logic        result_valid_q;
  logic        busy_q;
  logic        overrun_q;
  logic        timeout_q;

  logic [63:0] chain_sel_d;
  logic [15:0] cnt_d;
  logic        req_while_busy;

  // A same-cycle IV load takes effect before the block is chained.
  assign chain_sel_d    = iv_load ? iv_in : chain_q;
  assign cnt_d          = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign req_while_busy = (state_q != S_IDLE) && (start || iv_load);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q        <= S_IDLE;
      chain_q        <= '0;
      saved_ct_q     <= '0;
      des_data_q     <= '0;
      result_data_q  <= '0;
      cnt_q          <= '0;
      des_enable_q   <= 1'b0;
      mode_q         <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      des_enable_q   <= 1'b0;
      result_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (iv_load) begin
            chain_q   <= iv_in;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
          end
          if (start) begin
            mode_q       <= mode;
            des_data_q   <= mode ? (data_in ^ chain_sel_d) : data_in;
            if (!mode) begin
              saved_ct_q <= data_in;
            end
            des_enable_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (des_done) begin
            if (mode_q) begin
              result_data_q <= des_result;
              chain_q       <= des_result;
            end else begin
              result_data_q <= des_result ^ chain_q;
              chain_q       <= saved_ct_q;
            end
            result_valid_q <= 1'b1;
            state_q        <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_d;
            // Abandon the block once the counter reaches the limit.
            if (cnt_d == TIMEOUT_LIM) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end

        S_OUTPUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase

      if (req_while_busy) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign des_enable    = des_enable_q;
  assign des_encr_decr = mode_q;
  assign des_data      = des_data_q;
  assign result_valid  = result_valid_q;
  assign result_data   = result_data_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_cbc_chain_controller.sv
// Randomized bench for cbc_chain_controller against a block-level CBC model.
module tb_cbc_chain_controller;

  logic        HCLK;
  logic        HRESET;
  logic        start;
  logic        mode;
  logic [63:0] data_in;
  logic        iv_load;
  logic [63:0] iv_in;
  logic        des_enable;
  logic        des_encr_decr;
  logic [63:0] des_data;
  logic [63:0] des_result;
  logic        des_done;
  logic        result_valid;
  logic [63:0] result_data;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural CBC state, advanced per whole block.
  logic [63:0] m_chain;
  logic [63:0] m_res;
  logic        m_ovr;
  logic        m_to;

  cbc_chain_controller #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .start        (start),
    .mode         (mode),
    .data_in      (data_in),
    .iv_load      (iv_load),
    .iv_in        (iv_in),
    .des_enable   (des_enable),
    .des_encr_decr(des_encr_decr),
    .des_data     (des_data),
    .des_result   (des_result),
    .des_done     (des_done),
    .result_valid (result_valid),
    .result_data  (result_data),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One block: ISSUE, lat quiet WAIT cycles, then des_done with core_out (or no
  // response at all). ovr_at >= 0 injects a request during that WAIT cycle.
  task automatic run_block(input bit md, input logic [63:0] din, input bit ld,
                           input logic [63:0] iv, input int lat, input int ovr_at,
                           input bit ovr_iv, input bit never_done,
                           input bit invert_core, input logic [63:0] core_rand);
    logic [63:0] exp_dd;
    logic [63:0] core_out;
    start   = 1'b1;
    mode    = md;
    data_in = din;
    iv_load = ld;
    iv_in   = iv;
    if (ld) begin
      m_chain = iv;
      m_ovr   = 1'b0;
      m_to    = 1'b0;
    end
    exp_dd = md ? (din ^ m_chain) : din;
    tick();
    start   = 1'b0;
    iv_load = 1'b0;
    check("issue_en", {63'd0, des_enable}, 64'd1);
    check("issue_dd", des_data, exp_dd);
    check("issue_mode", {63'd0, des_encr_decr}, {63'd0, md});
    check("issue_busy", {63'd0, busy}, 64'd1);

    if (never_done) begin
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("to_wait_busy", {63'd0, busy}, 64'd1);
        check("to_wait_flag", {63'd0, timeout}, {63'd0, m_to});
        check("to_wait_rv", {63'd0, result_valid}, 64'd0);
      end
      tick();
      m_to = 1'b1;
      check("to_flag", {63'd0, timeout}, 64'd1);
      check("to_busy", {63'd0, busy}, 64'd0);
      check("to_rv", {63'd0, result_valid}, 64'd0);
      check("to_res_hold", result_data, m_res);
      tick();
      check("to_rv_after", {63'd0, result_valid}, 64'd0);
      return;
    end

    for (int k = 0; k < lat; k++) begin
      tick();
      start   = 1'b0;
      iv_load = 1'b0;
      check("wait_en", {63'd0, des_enable}, 64'd0);
      check("wait_rv", {63'd0, result_valid}, 64'd0);
      check("wait_dd_hold", des_data, exp_dd);
      check("wait_ovr", {63'd0, overrun}, {63'd0, m_ovr});
      if (k == ovr_at) begin
        if (ovr_iv) begin
          iv_load = 1'b1;
          iv_in   = rand64();
        end else begin
          start   = 1'b1;
          mode    = ~md;
          data_in = rand64();
        end
        m_ovr = 1'b1;
      end
    end
    tick();
    start      = 1'b0;
    iv_load    = 1'b0;
    check("done_dd_hold", des_data, exp_dd);
    core_out   = invert_core ? ~exp_dd : core_rand;
    des_done   = 1'b1;
    des_result = core_out;
    tick();
    des_done   = 1'b0;
    des_result = rand64();
    if (md) begin
      m_res   = core_out;
      m_chain = core_out;
    end else begin
      m_res   = core_out ^ m_chain;
      m_chain = din;
    end
    check("out_rv", {63'd0, result_valid}, 64'd1);
    check("out_res", result_data, m_res);
    check("out_busy", {63'd0, busy}, 64'd1);
    check("out_ovr", {63'd0, overrun}, {63'd0, m_ovr});
    check("out_to", {63'd0, timeout}, {63'd0, m_to});
    tick();
    check("idle_rv", {63'd0, result_valid}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_res_hold", result_data, m_res);
  endtask

  initial begin
    HRESET     = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    data_in    = '0;
    iv_load    = 1'b0;
    iv_in      = '0;
    des_result = '0;
    des_done   = 1'b0;
    m_chain    = '0;
    m_res      = '0;
    m_ovr      = 1'b0;
    m_to       = 1'b0;
    tick();
    tick();
    check("rst_en", {63'd0, des_enable}, 64'd0);
    check("rst_mode", {63'd0, des_encr_decr}, 64'd0);
    check("rst_dd", des_data, 64'd0);
    check("rst_rv", {63'd0, result_valid}, 64'd0);
    check("rst_res", result_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ovr", {63'd0, overrun}, 64'd0);
    check("rst_to", {63'd0, timeout}, 64'd0);
    HRESET = 1'b1;
    tick();

    // Encrypt chain with an inverting core, three cycles of latency.
    run_block(1'b1, 64'h0123456789ABCDEF, 1'b1, 64'd0, 2, -1, 1'b0, 1'b0, 1'b1, 64'd0);
    check("enc1_res", result_data, 64'hFEDCBA9876543210);
    start = 1'b1; mode = 1'b1; data_in = 64'd0;
    tick();
    start = 1'b0;
    check("enc2_dd", des_data, 64'hFEDCBA9876543210);
    tick();
    des_done = 1'b1; des_result = 64'h0;
    tick();
    des_done = 1'b0;
    m_res = 64'h0; m_chain = 64'h0;
    tick();

    // Decrypt chain: separate IV load, then verify chain via an encrypt of zero.
    iv_load = 1'b1; iv_in = 64'h1111111111111111;
    tick();
    iv_load = 1'b0;
    m_chain = 64'h1111111111111111; m_ovr = 1'b0; m_to = 1'b0;
    run_block(1'b0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'd0, 1, -1, 1'b0, 1'b0, 1'b0,
              64'h5555555555555555);
    check("dec_res", result_data, 64'h4444444444444444);
    run_block(1'b1, 64'd0, 1'b0, 64'd0, 0, -1, 1'b0, 1'b0, 1'b0, rand64());

    // Overrun during WAIT, then cleared by an idle IV load.
    run_block(1'b1, rand64(), 1'b0, 64'd0, 3, 1, 1'b0, 1'b0, 1'b0, rand64());
    check("ovr_sticky", {63'd0, overrun}, 64'd1);
    iv_load = 1'b1; iv_in = rand64();
    tick();
    iv_load = 1'b0;
    m_chain = iv_in; m_ovr = 1'b0; m_to = 1'b0;
    check("ovr_clear", {63'd0, overrun}, 64'd0);

    // Timeout, then completion exactly on the limit cycle.
    run_block(1'b1, rand64(), 1'b1, rand64(), 0, -1, 1'b0, 1'b1, 1'b0, 64'd0);
    run_block(1'b0, rand64(), 1'b1, rand64(), 7, -1, 1'b0, 1'b0, 1'b0, rand64());
    check("edge_to_clear", {63'd0, timeout}, 64'd0);

    // Simultaneous IV load and start.
    run_block(1'b1, 64'h0F, 1'b1, 64'hFF, 1, -1, 1'b0, 1'b0, 1'b0, rand64());

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        run_block(1'($urandom), rand64(), 1'b1, rand64(), 0, -1, 1'b0, 1'b1, 1'b0, 64'd0);
      end else begin
        int lat;
        int oat;
        lat = int'($urandom_range(0, 7));
        oat = (($urandom_range(0, 4) == 0) && lat > 0) ? int'($urandom_range(0, lat - 1)) : -1;
        run_block(1'($urandom), rand64(), ($urandom_range(0, 3) == 0), rand64(), lat, oat,
                  1'($urandom), 1'b0, 1'($urandom), rand64());
      end
      if ($urandom_range(0, 2) == 0) begin
        des_done = 1'b1; des_result = rand64();
        tick();
        des_done = 1'b0;
        tick();
        check("stray_done_rv", {63'd0, result_valid}, 64'd0);
        check("stray_done_busy", {63'd0, busy}, 64'd0);
        check("stray_done_res", result_data, m_res);
      end
      if ($urandom_range(0, 5) == 0) begin
        iv_load = 1'b1; iv_in = rand64();
        tick();
        iv_load = 1'b0;
        m_chain = iv_in; m_ovr = 1'b0; m_to = 1'b0;
        check("ivl_ovr", {63'd0, overrun}, 64'd0);
        check("ivl_to", {63'd0, timeout}, 64'd0);
      end
    end

    // Reset during WAIT aborts immediately; a late des_done is ignored.
    start = 1'b1; mode = 1'b1; data_in = rand64();
    tick();
    start = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_dd", des_data, 64'd0);
    check("mid_rst_res", result_data, 64'd0);
    check("mid_rst_mode", {63'd0, des_encr_decr}, 64'd0);
    check("mid_rst_en", {63'd0, des_enable}, 64'd0);
    check("mid_rst_flags", {62'd0, overrun, timeout}, 64'd0);
    tick();
    HRESET = 1'b1;
    m_chain = '0; m_res = '0; m_ovr = 1'b0; m_to = 1'b0;
    tick();
    des_done = 1'b1; des_result = rand64();
    tick();
    des_done = 1'b0;
    check("post_rst_rv", {63'd0, result_valid}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    check("post_rst_rv2", {63'd0, result_valid}, 64'd0);
    check("post_rst_res", result_data, 64'd0);
    // Chain is zero after reset, so an encrypt passes data straight through.
    run_block(1'b1, 64'h00000000DEADBEEF, 1'b0, 64'd0, 1, -1, 1'b0, 1'b0, 1'b0, rand64());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
